// File: rtl/bcd_to_bin_seq_if.sv
// ----------------------------------------------------------------------------
// bcd_to_bin_seq_if
//   Handshake bundle between a BCD digit source, the bcd_to_bin_seq
//   converter and the consumer of its signed binary result.
//
//   Input side : in_valid, in_ready, bcd_in[4*NDIGITS-1:0]
//   Output side: out_valid, out_ready, binout[OUT_W-1:0], neg, err, ovf
//
//   master : the environment (drives requests, accepts results)
//   slave  : the converter
// ----------------------------------------------------------------------------
interface bcd_to_bin_seq_if #(
    parameter int NDIGITS = 4,
    parameter int OUT_W   = 11
) ();

    logic                   in_valid;
    logic                   in_ready;
    logic [4*NDIGITS-1:0]   bcd_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_W-1:0]       binout;
    logic                   neg;
    logic                   err;
    logic                   ovf;

    modport master (
        output in_valid, bcd_in, out_ready,
        input  in_ready, out_valid, binout, neg, err, ovf
    );

    modport slave (
        input  in_valid, bcd_in, out_ready,
        output in_ready, out_valid, binout, neg, err, ovf
    );

endinterface

// File: rtl/bcd_to_bin_seq.sv
// ----------------------------------------------------------------------------
// bcd_to_bin_seq
//   Sequential BCD-to-signed-binary converter. A packed word of NDIGITS
//   4-bit digit codes is folded one slot per clock, most significant first,
//   into an unsigned accumulator; the result is then saturated into a signed
//   OUT_W-bit value with negative / error / overflow flags.
//
//   Digit codes: 0x0-0x9 numeric, 0xE minus sign, 0xF blank (skipped),
//   0xA-0xD invalid.
//
//   Ports:
//     clk  - system clock, all state changes on the rising edge
//     rst  - synchronous active-high reset
//     bus  - slave side of bcd_to_bin_seq_if
//              in_valid/in_ready/bcd_in         : request handshake
//              out_valid/out_ready              : result handshake
//              binout/neg/err/ovf               : registered result
//
//   Latency: a word accepted at edge k yields out_valid after edge
//   k+NDIGITS+1.
// ----------------------------------------------------------------------------
module bcd_to_bin_seq #(
    parameter int NDIGITS = 4,
    parameter int OUT_W   = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_to_bin_seq_if.slave      bus
);

    localparam int SW = 4 * NDIGITS;               // shift register width
    localparam int AW = 4 * NDIGITS + 1;           // accumulator width
    localparam int IW = $clog2(NDIGITS);           // slot index width
    localparam int CW = ((AW > OUT_W) ? AW : OUT_W) + 1;  // compare width

    localparam logic [CW-1:0]    POS_MAX = (CW'(1) << (OUT_W - 1)) - CW'(1);
    localparam logic [CW-1:0]    NEG_MAG = CW'(1) << (OUT_W - 1);
    localparam logic [OUT_W-1:0] POS_SAT = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] NEG_SAT = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [SW-1:0]   sreg;       // remaining digit slots, current one on top
    logic [AW-1:0]   acc;        // unsigned magnitude, cannot wrap (10 < 16)
    logic [IW-1:0]   idx;        // slot currently being folded
    logic [1:0]      scnt;       // sign codes seen, saturates at 2
    logic            bad;        // an invalid code was seen

    logic [3:0]      digit;
    logic [AW-1:0]   acc_mul;
    logic [CW-1:0]   acc_w;
    logic [OUT_W-1:0] neg_out;
    logic            is_err;
    logic            is_neg;

    assign digit   = sreg[SW-1 -: 4];
    assign acc_mul = (acc << 3) + (acc << 1) + AW'(digit);
    assign acc_w   = CW'(acc);
    assign neg_out = -acc_w[OUT_W-1:0];
    // scnt saturates at 2, so bit 1 means "two or more sign codes"
    assign is_err  = bad | scnt[1];
    assign is_neg  = (scnt == 2'd1);

    assign bus.in_ready = (state == IDLE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default first, so no path through the case leaves
        // state_nxt unassigned and infers a latch.
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid)       state_nxt = CONV;
            CONV: if (idx == '0)          state_nxt = FIN;
            FIN:                          state_nxt = DONE;
            DONE: if (bus.out_ready)      state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg          <= '0;
            acc           <= '0;
            idx           <= '0;
            scnt          <= '0;
            bad           <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.binout    <= '0;
            bus.neg       <= 1'b0;
            bus.err       <= 1'b0;
            bus.ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sreg <= bus.bcd_in;
                        acc  <= '0;
                        scnt <= '0;
                        bad  <= 1'b0;
                        idx  <= IW'(NDIGITS - 1);
                    end
                end

                CONV: begin
                    sreg <= {sreg[SW-5:0], 4'h0};
                    idx  <= idx - 1'b1;
                    if (digit <= 4'd9) begin
                        acc <= acc_mul;
                    end else if (digit == 4'hE) begin
                        if (scnt != 2'd2) scnt <= scnt + 2'd1;
                    end else if (digit != 4'hF) begin
                        bad <= 1'b1;
                    end
                end

                FIN: begin
                    bus.out_valid <= 1'b1;
                    if (is_err) begin
                        bus.err    <= 1'b1;
                        bus.neg    <= 1'b0;
                        bus.ovf    <= 1'b0;
                        bus.binout <= '0;
                    end else begin
                        bus.err <= 1'b0;
                        bus.neg <= is_neg;
                        // The negative range is one wider than the positive.
                        if (is_neg) begin
                            bus.ovf    <= (acc_w > NEG_MAG);
                            bus.binout <= (acc_w > NEG_MAG) ? NEG_SAT : neg_out;
                        end else begin
                            bus.ovf    <= (acc_w > POS_MAX);
                            bus.binout <= (acc_w > POS_MAX) ? POS_SAT
                                                            : acc_w[OUT_W-1:0];
                        end
                    end
                end

                DONE: begin
                    if (bus.out_ready) bus.out_valid <= 1'b0;
                end

                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// ----------------------------------------------------------------------------
// tb_bcd_to_bin_seq
//   Self-checking bench for bcd_to_bin_seq: a 4-digit and a 5-digit instance
//   (both OUT_W=11), table-driven vectors, hand-written backpressure and
//   reset sequences, and random words checked against a arithmetic model.
// ----------------------------------------------------------------------------
module tb_bcd_to_bin_seq;

    logic clk;
    logic rst;

    bcd_to_bin_seq_if #(.NDIGITS(4), .OUT_W(11)) bus4 ();
    bcd_to_bin_seq_if #(.NDIGITS(5), .OUT_W(11)) bus5 ();

    bcd_to_bin_seq #(.NDIGITS(4), .OUT_W(11)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    bcd_to_bin_seq #(.NDIGITS(5), .OUT_W(11)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [19:0] bcd;
        logic [10:0] bin;
        logic        neg;
        logic        err;
        logic        ovf;
    } vec_t;

    vec_t tab4[14];
    vec_t tab5[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: evaluate the number arithmetically, then clamp to range.
    function automatic void model(input logic [19:0] w, input int n,
                                  output logic [10:0] b, output logic mn,
                                  output logic me, output logic mo);
        longint mag;
        longint v;
        int     signs;
        bit     bad;
        mag = 0; signs = 0; bad = 0;
        for (int i = n - 1; i >= 0; i--) begin
            logic [3:0] d;
            d = w[4*i +: 4];
            if (d <= 4'd9)       mag = mag * 10 + longint'(d);
            else if (d == 4'hE)  signs++;
            else if (d != 4'hF)  bad = 1;
        end
        me = bad || (signs >= 2);
        if (me) begin
            b = '0; mn = 1'b0; mo = 1'b0;
            return;
        end
        mn = (signs == 1);
        v  = mn ? -mag : mag;
        mo = 1'b0;
        if (v > 1023)  begin v = 1023;  mo = 1'b1; end
        if (v < -1024) begin v = -1024; mo = 1'b1; end
        b = 11'(v);
    endfunction

    task automatic apply4(input logic [15:0] v, output logic [10:0] b,
                          output logic n, output logic e, output logic o);
        int cyc;
        cyc = 0;
        while (!bus4.in_ready && cyc < 50) begin @(negedge clk); cyc++; end
        check("in_ready_idle4", 32'(bus4.in_ready), 1);
        bus4.bcd_in    = v;
        bus4.in_valid  = 1'b1;
        bus4.out_ready = 1'b1;   // held high early: must be ignored until valid
        @(negedge clk);
        bus4.in_valid = 1'b0;
        bus4.bcd_in   = ~v;      // must not disturb the conversion
        check("in_ready_busy4", 32'(bus4.in_ready), 0);
        cyc = 0;
        while (!bus4.out_valid && cyc < 50) begin @(negedge clk); cyc++; end
        check("latency4", cyc, 5);
        b = bus4.binout; n = bus4.neg; e = bus4.err; o = bus4.ovf;
        @(negedge clk);
        bus4.out_ready = 1'b0;
        check("out_valid_drop4", 32'(bus4.out_valid), 0);
        check("in_ready_back4", 32'(bus4.in_ready), 1);
    endtask

    task automatic apply5(input logic [19:0] v, output logic [10:0] b,
                          output logic n, output logic e, output logic o);
        int cyc;
        cyc = 0;
        while (!bus5.in_ready && cyc < 50) begin @(negedge clk); cyc++; end
        bus5.bcd_in   = v;
        bus5.in_valid = 1'b1;
        @(negedge clk);
        bus5.in_valid = 1'b0;
        bus5.bcd_in   = ~v;
        cyc = 0;
        while (!bus5.out_valid && cyc < 50) begin @(negedge clk); cyc++; end
        check("latency5", cyc, 6);
        b = bus5.binout; n = bus5.neg; e = bus5.err; o = bus5.ovf;
        bus5.out_ready = 1'b1;
        @(negedge clk);
        bus5.out_ready = 1'b0;
        check("out_valid_drop5", 32'(bus5.out_valid), 0);
    endtask

    function automatic logic [19:0] rand_word(input int n);
        logic [19:0] w;
        int r;
        w = '0;
        for (int i = 0; i < n; i++) begin
            r = int'($urandom_range(0, 19));
            if (r < 12)      w[4*i +: 4] = 4'(r % 10);
            else if (r < 15) w[4*i +: 4] = 4'hF;
            else if (r < 18) w[4*i +: 4] = 4'hE;
            else             w[4*i +: 4] = 4'(4'hA + 4'(r - 18));
        end
        return w;
    endfunction

    initial begin
        logic [10:0] b, mb;
        logic        n, e, o, mn, me, mo;
        int          cyc;

        tab4[0]  = '{20'h0F123, 11'd123,  1'b0, 1'b0, 1'b0};
        tab4[1]  = '{20'h0E042, 11'h7D6,  1'b1, 1'b0, 1'b0};
        tab4[2]  = '{20'h01999, 11'd1023, 1'b0, 1'b0, 1'b1};
        tab4[3]  = '{20'h012A4, 11'd0,    1'b0, 1'b1, 1'b0};
        tab4[4]  = '{20'h0EE12, 11'd0,    1'b0, 1'b1, 1'b0};
        tab4[5]  = '{20'h0FFFF, 11'd0,    1'b0, 1'b0, 1'b0};
        tab4[6]  = '{20'h0000E, 11'd0,    1'b1, 1'b0, 1'b0};
        tab4[7]  = '{20'h0E999, 11'h419,  1'b1, 1'b0, 1'b0};
        tab4[8]  = '{20'h01023, 11'd1023, 1'b0, 1'b0, 1'b0};
        tab4[9]  = '{20'h01024, 11'd1023, 1'b0, 1'b0, 1'b1};
        tab4[10] = '{20'h09E99, 11'h419,  1'b1, 1'b0, 1'b0};
        tab4[11] = '{20'h01F2F, 11'd12,   1'b0, 1'b0, 1'b0};
        tab4[12] = '{20'h00000, 11'd0,    1'b0, 1'b0, 1'b0};
        tab4[13] = '{20'h0EEE1, 11'd0,    1'b0, 1'b1, 1'b0};

        tab5[0]  = '{20'hE1024, 11'h400,  1'b1, 1'b0, 1'b0};
        tab5[1]  = '{20'hE1025, 11'h400,  1'b1, 1'b0, 1'b1};
        tab5[2]  = '{20'h99999, 11'd1023, 1'b0, 1'b0, 1'b1};
        tab5[3]  = '{20'hE1023, 11'h401,  1'b1, 1'b0, 1'b0};
        tab5[4]  = '{20'h0B000, 11'd0,    1'b0, 1'b1, 1'b0};

        bus4.in_valid = 1'b0; bus4.bcd_in = '0; bus4.out_ready = 1'b0;
        bus5.in_valid = 1'b0; bus5.bcd_in = '0; bus5.out_ready = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready",  32'(bus4.in_ready),  1);
        check("rst_out_valid", 32'(bus4.out_valid), 0);
        check("rst_binout",    32'(bus4.binout),    0);
        check("rst_flags",     32'({bus4.neg, bus4.err, bus4.ovf}), 0);

        // Table vectors
        foreach (tab4[i]) begin
            apply4(tab4[i].bcd[15:0], b, n, e, o);
            check($sformatf("tab4[%0d].binout", i), 32'(b), 32'(tab4[i].bin));
            check($sformatf("tab4[%0d].flags", i), 32'({n, e, o}),
                  32'({tab4[i].neg, tab4[i].err, tab4[i].ovf}));
        end
        foreach (tab5[i]) begin
            apply5(tab5[i].bcd, b, n, e, o);
            check($sformatf("tab5[%0d].binout", i), 32'(b), 32'(tab5[i].bin));
            check($sformatf("tab5[%0d].flags", i), 32'({n, e, o}),
                  32'({tab5[i].neg, tab5[i].err, tab5[i].ovf}));
        end

        // Backpressure: result held for 4 cycles with out_ready low
        bus4.bcd_in = 16'h0007; bus4.in_valid = 1'b1; bus4.out_ready = 1'b0;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        cyc = 0;
        while (!bus4.out_valid && cyc < 50) begin @(negedge clk); cyc++; end
        check("bp_latency", cyc, 5);
        for (int i = 0; i < 4; i++) begin
            check("bp_hold_valid",  32'(bus4.out_valid), 1);
            check("bp_hold_binout", 32'(bus4.binout),    7);
            check("bp_hold_ready",  32'(bus4.in_ready),  0);
            @(negedge clk);
        end
        bus4.out_ready = 1'b1;
        @(negedge clk);
        bus4.out_ready = 1'b0;
        check("bp_valid_drop", 32'(bus4.out_valid), 0);
        check("bp_in_ready",   32'(bus4.in_ready),  1);
        check("bp_kept_binout", 32'(bus4.binout),   7);
        apply4(16'h0042, b, n, e, o);
        check("bp_second", 32'({b, n, e, o}), 32'({11'd42, 3'b000}));

        // Reset during the 2nd CONV cycle discards the conversion
        bus4.bcd_in = 16'h0999; bus4.in_valid = 1'b1;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_in_ready",  32'(bus4.in_ready),  1);
        check("mid_rst_out_valid", 32'(bus4.out_valid), 0);
        check("mid_rst_binout",    32'(bus4.binout),    0);
        check("mid_rst_flags",     32'({bus4.neg, bus4.err, bus4.ovf}), 0);
        repeat (7) @(negedge clk);
        check("mid_rst_no_result", 32'(bus4.out_valid), 0);
        apply4(16'h0005, b, n, e, o);
        check("post_rst_binout", 32'(b), 5);

        // Random words against the model
        for (int i = 0; i < 60; i++) begin
            logic [19:0] w;
            w = rand_word(4);
            model(w, 4, mb, mn, me, mo);
            apply4(w[15:0], b, n, e, o);
            check($sformatf("rnd4 %h", w[15:0]), 32'({b, n, e, o}), 32'({mb, mn, me, mo}));
        end
        for (int i = 0; i < 20; i++) begin
            logic [19:0] w;
            w = rand_word(5);
            model(w, 5, mb, mn, me, mo);
            apply5(w, b, n, e, o);
            check($sformatf("rnd5 %h", w), 32'({b, n, e, o}), 32'({mb, mn, me, mo}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
Sequential, parametrised BCD-to-signed-binary converter for the calculator datapath. It takes a packed word of NDIGITS 4-bit digit codes from keypad/display storage and folds one digit per clock, most significant first. The result is a saturated two's-complement value with negative, error and overflow flags. It uses a ready/valid handshake on both sides so the ALU front end can stall it.

Parameters:
NDIGITS, 4, number of 4-bit digit slots in bcd_in (min 2)
OUT_W, 11, width of signed binout (min 4)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  bcd_in is presented
in_ready  output  1  converter idle, can accept
bcd_in  input  4*NDIGITS  digit codes; slot i = bcd_in[4i+3:4i], slot NDIGITS-1 most significant
out_valid  output  1  result registers hold a completed conversion
out_ready  input  1  consumer accepts the result
binout  output  OUT_W  signed result
neg  output  1  a sign code was present
err  output  1  invalid input
ovf  output  1  magnitude exceeded range; binout saturated

Behaviour:
Interface:
- One clock, clk.
- rst is synchronous and active-high.

Digit codes:
- 0x0-0x9: numeric.
- 0xE: minus sign.
- 0xF: blank, skipped with no shift.
- 0xA-0xD: invalid.

States: IDLE, CONV, FIN, DONE.

Reset:
- state=IDLE; in_ready=1.
- out_valid=0, binout=0, neg=0, err=0, ovf=0.
- Internal accumulator, digit index, sign count and bad flag cleared.
- Reset in any state, including mid-CONV or DONE, discards the conversion in progress.

IDLE:
- in_ready=1.
- On in_valid=1: capture bcd_in into a shift register.
- Clear acc, sign count and bad flag; set index=NDIGITS-1; go to CONV.
- in_ready is 0 in every other state.

CONV (exactly NDIGITS cycles, one slot per cycle, MSB first):
- Numeric digit: acc <= acc*10 + d.
- 0xE: sign count increments, saturating at 2.
- 0xF: no change.
- 0xA-0xD: bad <= 1.
- After slot 0 is processed, go to FIN.
- acc is unsigned, 4*NDIGITS+1 bits wide, and never wraps.

FIN (1 cycle), registers the outputs:
- err = bad OR (sign count ≥ 2). If err: binout=0, neg=0, ovf=0.
- Otherwise neg = (sign count == 1).
- Positive limit: acc > 2^(OUT_W-1)-1 gives ovf=1, binout = 2^(OUT_W-1)-1.
- Negative limit: acc > 2^(OUT_W-1) gives ovf=1, binout = -2^(OUT_W-1).
- Otherwise binout = neg ? -acc : acc, truncated to OUT_W bits.
- A sign code in any slot position negates the whole number.
- "-0" gives binout=0 with neg=1.
- out_valid <= 1; go to DONE.

Timing:
- Acceptance at edge k: out_valid rises after edge k+NDIGITS+1. For NDIGITS=4 that is 5 clocks.

DONE:
- binout, neg, err and ovf are held stable while out_valid=1.
- On out_ready=1: out_valid <= 0, go to IDLE. in_ready is 1 the following cycle.
- Output registers keep their last values after the handshake until the next FIN.
- out_ready while out_valid=0 is ignored.
- No overlap: a new input is accepted at the earliest one cycle after the result handshake.

Boundary cases:
- bcd_in changing while not in IDLE has no effect.
- All-blank input gives binout=0, no flags.
- Leading zeros are harmless.

Test Plan:
- NDIGITS=4, OUT_W=11:
  - bcd_in=16'hF123, out_ready=1 → out_valid rises 5 clocks after accept; binout=123, neg=0, err=0, ovf=0.
  - bcd_in=16'hE042 → binout=-42 (11'h7D6), neg=1.
  - bcd_in=16'h1999 → ovf=1, binout=1023, err=0.
  - bcd_in=16'h12A4 → err=1, binout=0, neg=0, ovf=0.
  - bcd_in=16'hEE12 → err=1, binout=0.
- NDIGITS=5, OUT_W=11:
  - bcd_in=20'hE1024 → binout=-1024, ovf=0.
  - bcd_in=20'hE1025 → ovf=1, binout=-1024.
- Backpressure: bcd_in=16'h0007 with out_ready=0 for 4 cycles after out_valid → outputs hold binout=7 and in_ready=0 throughout. Then out_ready=1 for 1 cycle → out_valid=0 and in_ready=1 next cycle. A second input is accepted and gives its own correct result.
- Reset mid-operation: rst=1 during the 2nd CONV cycle of 16'h0999 → next cycle state IDLE, in_ready=1, out_valid=0, all outputs 0. A fresh 16'h0005 then gives binout=5.
- Blank/zero handling: bcd_in=16'hFFFF → binout=0, no flags. bcd_in=16'h000E → binout=0, neg=1, err=0.
